// File: rtl/pc_gen_if.sv
// Instruction-memory request bus between the fetch PC generator and imem.
// Carries the fetch address, its valid/ready handshake and the misalignment flag.
// The master drives address/valid/adel; the slave answers with ready.
interface pc_gen_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] pc_out;
  logic             adel;

  modport master (
    output req_valid,
    output pc_out,
    output adel,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  pc_out,
    input  adel,
    output req_ready
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: sequential/branch/exception/ERET next-address select.
// Latency: every redirect or increment appears on pc_out one cycle after its edge.
// Backpressure: address held while req_valid & ~req_ready; a branch seen then is parked in BR_PEND.
module pc_gen #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'hbfc0_0000,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'hbfc0_0380,
  parameter int unsigned      INC       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena_i,
  input  logic             br_valid_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             exc_valid_i,
  input  logic             eret_valid_i,
  input  logic [WIDTH-1:0] epc_i,
  pc_gen_if.master         req
);

  localparam logic [1:0] S_BOOT    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_BR_PEND = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             req_valid;
  logic             fire;

  assign req_valid     = ena_i & (state_q != S_BOOT);
  assign fire          = req_valid & req.req_ready;
  assign req.req_valid = req_valid;
  assign req.pc_out    = pc_q;
  assign req.adel      = |pc_q[1:0];

  // Next-address select: exc > eret > pending-branch consumption > new branch > increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    case (state_q)
      S_BOOT: begin
        // PC is held for the boot cycle; requests start next cycle.
        state_d = S_RUN;
      end
      S_RUN: begin
        if (exc_valid_i) begin
          pc_d = EXC_VEC;
        end else if (eret_valid_i) begin
          pc_d = epc_i;
        end else if (br_valid_i) begin
          if (fire) begin
            // Delay slot accepted this cycle, so the target is next.
            pc_d = br_target_i;
          end else begin
            // Delay slot still unfetched: remember the target.
            pend_d  = br_target_i;
            state_d = S_BR_PEND;
          end
        end else if (fire) begin
          pc_d = pc_q + WIDTH'(INC);
        end
      end
      S_BR_PEND: begin
        // A new br_valid here cannot happen (no branch in a delay slot), so it is ignored.
        if (exc_valid_i) begin
          pc_d    = EXC_VEC;
          state_d = S_RUN;
        end else if (eret_valid_i) begin
          pc_d    = epc_i;
          state_d = S_RUN;
        end else if (fire) begin
          pc_d    = pend_q;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_BOOT;
        pc_d    = RESET_VEC;
      end
    endcase
  end

  // State registers with synchronous reset back to the boot vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VEC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with a scoreboard queue of expected per-cycle outputs.
// The driver applies one cycle of inputs and pushes the outputs expected during that cycle.
// A monitor pops and compares on every falling edge while expectations are queued.
module tb_pc_gen;

  typedef struct packed {
    logic [31:0] pc;
    logic        vld;
    logic        adel;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_valid;
  logic        eret_valid;
  logic [31:0] epc;

  int n_checks;
  int n_pass;
  exp_t sb_q[$];

  pc_gen_if #(.WIDTH(32)) mem_if ();

  pc_gen dut (
    .clk          (clk),
    .rst          (rst),
    .ena_i        (ena),
    .br_valid_i   (br_valid),
    .br_target_i  (br_target),
    .exc_valid_i  (exc_valid),
    .eret_valid_i (eret_valid),
    .epc_i        (epc),
    .req          (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare DUT outputs against the oldest expectation each cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      if (mem_if.pc_out === e.pc && mem_if.req_valid === e.vld && mem_if.adel === e.adel) begin
        n_pass++;
      end else begin
        $display("FAIL cycle%0d: got pc=%h vld=%b adel=%b, expected pc=%h vld=%b adel=%b",
                 n_checks, mem_if.pc_out, mem_if.req_valid, mem_if.adel, e.pc, e.vld, e.adel);
      end
    end
  end

  // One cycle of stimulus plus the outputs expected while it is applied.
  task automatic step(input logic r, input logic en, input logic rdy,
                      input logic bv, input logic [31:0] bt,
                      input logic xv, input logic ev, input logic [31:0] ep,
                      input logic [31:0] exp_pc, input logic exp_vld, input logic exp_adel);
    exp_t e;
    rst               = r;
    ena               = en;
    mem_if.req_ready  = rdy;
    br_valid          = bv;
    br_target         = bt;
    exc_valid         = xv;
    eret_valid        = ev;
    epc               = ep;
    e.pc   = exp_pc;
    e.vld  = exp_vld;
    e.adel = exp_adel;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; ena = 1'b0; mem_if.req_ready = 1'b0;
    br_valid = 1'b0; br_target = '0; exc_valid = 1'b0; eret_valid = 1'b0; epc = '0;
    @(posedge clk);
    #1;
    //    rst en rdy bv bt            xv ev epc           exp_pc        vld adel
    // Reset and boot
    step(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0000, 0, 0);
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0000, 0, 0); // BOOT cycle
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0000, 1, 0);
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0004, 1, 0);
    // Stall at ...08
    step(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0008, 0, 0);
    step(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0008, 0, 0);
    step(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0008, 0, 0);
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0008, 1, 0);
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_000c, 1, 0);
    // Branch with delay slot accepted
    step(0, 1, 1, 1, 32'h8000_0100, 0, 0, 32'h0,       32'hbfc0_0010, 1, 0);
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h8000_0100, 1, 0);
    // ERET back to ...10 to replay the branch under backpressure
    step(0, 1, 1, 0, 32'h0,        0, 1, 32'hbfc0_0010, 32'h8000_0104, 1, 0);
    step(0, 1, 0, 1, 32'h8000_0100, 0, 0, 32'h0,       32'hbfc0_0010, 1, 0); // -> BR_PEND
    step(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0010, 1, 0); // held
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0010, 1, 0); // delay slot fires
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h8000_0100, 1, 0);
    // Exception in BR_PEND discards the pending branch
    step(0, 1, 0, 1, 32'h1234_0000, 0, 0, 32'h0,       32'h8000_0104, 1, 0); // -> BR_PEND
    step(0, 1, 0, 0, 32'h0,        1, 0, 32'h0,        32'h8000_0104, 1, 0); // exc overrides
    step(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0380, 1, 0);
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0380, 1, 0);
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0384, 1, 0); // no jump to 1234_0000
    // exc and eret together: exception wins
    step(0, 1, 1, 0, 32'h0,        1, 1, 32'h8000_0202, 32'hbfc0_0388, 1, 0);
    // ERET to a misaligned address
    step(0, 1, 0, 0, 32'h0,        0, 1, 32'h8000_0202, 32'hbfc0_0380, 1, 0);
    step(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h8000_0202, 1, 1);
    // Wrap from ffff_fffc
    step(0, 1, 0, 0, 32'h0,        0, 1, 32'hffff_fffc, 32'h8000_0202, 1, 1);
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'hffff_fffc, 1, 0);
    // exc with br_valid: exception wins, branch not captured
    step(0, 1, 1, 1, 32'h5555_0000, 1, 0, 32'h0,       32'h0000_0000, 1, 0);
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0380, 1, 0);
    // br_valid while in BR_PEND is ignored
    step(0, 1, 0, 1, 32'h8000_1000, 0, 0, 32'h0,       32'hbfc0_0384, 1, 0); // -> BR_PEND
    step(0, 1, 0, 1, 32'h9000_0000, 0, 0, 32'h0,       32'hbfc0_0384, 1, 0); // ignored
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0384, 1, 0);
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'h8000_1000, 1, 0);
    // Reset while in BR_PEND
    step(0, 1, 0, 1, 32'h7777_0000, 0, 0, 32'h0,       32'h8000_1004, 1, 0); // -> BR_PEND
    step(1, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h8000_1004, 1, 0);
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0000, 0, 0); // BOOT
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0000, 1, 0);
    step(0, 1, 1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0004, 1, 0);
    step(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0_0008, 1, 0); // not 7777_0000
    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
